// File: rtl/param_loader.sv
// Byte-stream parameter loader: fills conv/dense weight and bias memories in stream order.
// Optional trailing 16-bit checksum phase is enabled by defining PARAM_CHECKSUM_EN.
module param_loader #(
  parameter int N_CONV_W  = 2576,
  parameter int N_CONV_B  = 112,
  parameter int N_DENSE_W = 33792,
  parameter int N_DENSE_B = 192
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         cw_we,
  output logic [11:0]  cw_addr,
  output logic [143:0] cw_data,
  output logic         cb_we,
  output logic [6:0]   cb_addr,
  output logic [15:0]  cb_data,
  output logic         dw_we,
  output logic [15:0]  dw_addr,
  output logic [15:0]  dw_data,
  output logic         db_we,
  output logic [7:0]   db_addr,
  output logic [15:0]  db_data,
  output logic         busy,
  output logic         done,
  output logic         chk_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CW,
    S_LOAD_CB,
    S_LOAD_DW,
    S_LOAD_DB,
`ifdef PARAM_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  state_t r_state, w_next_state;

  logic         r_byte_sel;
  logic [7:0]   r_low_byte;
  logic [3:0]   r_param_cnt;
  logic [127:0] r_slots;
  logic [15:0]  r_idx;
  logic         r_cw_we, r_cb_we, r_dw_we, r_db_we;
  logic [11:0]  r_cw_addr;
  logic [143:0] r_cw_data;
  logic [6:0]   r_cb_addr;
  logic [15:0]  r_cb_data;
  logic [15:0]  r_dw_addr, r_dw_data;
  logic [7:0]   r_db_addr;
  logic [15:0]  r_db_data;

  logic         w_in_ready;
  logic         w_accept;
  logic [15:0]  w_param;
  logic         w_param_done;
  logic         w_word_done;
  logic [15:0]  w_last_idx;
  logic         w_idx_last;
  logic         w_phase_end;
  logic         w_start_load;

  assign w_accept     = in_valid && w_in_ready;
  assign w_param      = {in_data, r_low_byte};
  assign w_param_done = w_accept && r_byte_sel;
  assign w_word_done  = w_param_done && ((r_state != S_LOAD_CW) || (r_param_cnt == 4'd8));
  assign w_idx_last   = (r_idx == w_last_idx);
  assign w_phase_end  = w_word_done && w_idx_last;
  assign w_start_load = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_comb begin
    w_in_ready = 1'b0;
    w_last_idx = 16'd0;
    case (r_state)
      S_LOAD_CW: begin w_in_ready = 1'b1; w_last_idx = 16'(N_CONV_W - 1);  end
      S_LOAD_CB: begin w_in_ready = 1'b1; w_last_idx = 16'(N_CONV_B - 1);  end
      S_LOAD_DW: begin w_in_ready = 1'b1; w_last_idx = 16'(N_DENSE_W - 1); end
      S_LOAD_DB: begin w_in_ready = 1'b1; w_last_idx = 16'(N_DENSE_B - 1); end
`ifdef PARAM_CHECKSUM_EN
      S_CHECK:   w_in_ready = 1'b1;
`endif
      default:   w_in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Phase changes on the edge that accepts the final byte, so the stream never bubbles.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next_state = S_LOAD_CW;
      S_LOAD_CW: if (w_phase_end) w_next_state = S_LOAD_CB;
      S_LOAD_CB: if (w_phase_end) w_next_state = S_LOAD_DW;
      S_LOAD_DW: if (w_phase_end) w_next_state = S_LOAD_DB;
`ifdef PARAM_CHECKSUM_EN
      S_LOAD_DB: if (w_phase_end) w_next_state = S_CHECK;
      S_CHECK:   if (w_param_done) w_next_state = S_DONE;
`else
      S_LOAD_DB: if (w_phase_end) w_next_state = S_DONE;
`endif
      S_DONE:    if (start) w_next_state = S_LOAD_CW;
      default:   w_next_state = S_IDLE;
    endcase
  end

`ifdef PARAM_CHECKSUM_EN
  logic [15:0] r_sum;
  logic        r_chk_err;

  always_ff @(posedge clk) begin
    if (rst || w_start_load) begin
      r_sum     <= 16'd0;
      r_chk_err <= 1'b0;
    end else if (w_param_done) begin
      if (r_state == S_CHECK) r_chk_err <= (r_sum != w_param);
      else                    r_sum     <= r_sum + w_param;
    end
  end

  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_sel  <= 1'b0;
      r_low_byte  <= 8'd0;
      r_param_cnt <= 4'd0;
      r_slots     <= 128'd0;
      r_idx       <= 16'd0;
      r_cw_we     <= 1'b0;
      r_cb_we     <= 1'b0;
      r_dw_we     <= 1'b0;
      r_db_we     <= 1'b0;
      r_cw_addr   <= 12'd0;
      r_cw_data   <= 144'd0;
      r_cb_addr   <= 7'd0;
      r_cb_data   <= 16'd0;
      r_dw_addr   <= 16'd0;
      r_dw_data   <= 16'd0;
      r_db_addr   <= 8'd0;
      r_db_data   <= 16'd0;
    end else begin
      r_cw_we <= 1'b0;
      r_cb_we <= 1'b0;
      r_dw_we <= 1'b0;
      r_db_we <= 1'b0;
      if (w_start_load) begin
        r_byte_sel  <= 1'b0;
        r_param_cnt <= 4'd0;
        r_idx       <= 16'd0;
      end else if (w_accept) begin
        r_byte_sel <= ~r_byte_sel;
        if (!r_byte_sel) r_low_byte <= in_data;
        if (w_word_done && (r_state != S_IDLE) && (r_state != S_DONE)) begin
          r_idx <= w_idx_last ? 16'd0 : r_idx + 16'd1;
        end
        if (w_param_done) begin
          case (r_state)
            S_LOAD_CW: begin
              if (r_param_cnt == 4'd8) begin
                r_cw_we     <= 1'b1;
                r_cw_addr   <= r_idx[11:0];
                r_cw_data   <= {w_param, r_slots};
                r_param_cnt <= 4'd0;
              end else begin
                r_slots[{r_param_cnt[2:0], 4'b0000} +: 16] <= w_param;
                r_param_cnt <= r_param_cnt + 4'd1;
              end
            end
            S_LOAD_CB: begin
              r_cb_we   <= 1'b1;
              r_cb_addr <= r_idx[6:0];
              r_cb_data <= w_param;
            end
            S_LOAD_DW: begin
              r_dw_we   <= 1'b1;
              r_dw_addr <= r_idx;
              r_dw_data <= w_param;
            end
            S_LOAD_DB: begin
              r_db_we   <= 1'b1;
              r_db_addr <= r_idx[7:0];
              r_db_data <= w_param;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign in_ready = w_in_ready;
  assign busy     = w_in_ready;
  assign done     = (r_state == S_DONE);
  assign cw_we    = r_cw_we;
  assign cw_addr  = r_cw_addr;
  assign cw_data  = r_cw_data;
  assign cb_we    = r_cb_we;
  assign cb_addr  = r_cb_addr;
  assign cb_data  = r_cb_data;
  assign dw_we    = r_dw_we;
  assign dw_addr  = r_dw_addr;
  assign dw_data  = r_dw_data;
  assign db_we    = r_db_we;
  assign db_addr  = r_db_addr;
  assign db_data  = r_db_data;

endmodule

// File: tb/tb_param_loader.sv
// Directed self-checking bench for param_loader with small memory sizes.
// Covers both builds; checksum expectations switch on PARAM_CHECKSUM_EN.
module tb_param_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'd0;
  logic         in_ready;
  logic         cw_we;
  logic [11:0]  cw_addr;
  logic [143:0] cw_data;
  logic         cb_we;
  logic [6:0]   cb_addr;
  logic [15:0]  cb_data;
  logic         dw_we;
  logic [15:0]  dw_addr;
  logic [15:0]  dw_data;
  logic         db_we;
  logic [7:0]   db_addr;
  logic [15:0]  db_data;
  logic         busy;
  logic         done;
  logic         chk_err;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] tbSum;

  logic [15:0]  cwAddrQ[$];
  logic [143:0] cwDataQ[$];
  logic [15:0]  cbAddrQ[$], cbDataQ[$];
  logic [15:0]  dwAddrQ[$], dwDataQ[$];
  logic [15:0]  dbAddrQ[$], dbDataQ[$];

  param_loader #(
    .N_CONV_W(2), .N_CONV_B(3), .N_DENSE_W(4), .N_DENSE_B(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready),
    .cw_we(cw_we), .cw_addr(cw_addr), .cw_data(cw_data),
    .cb_we(cb_we), .cb_addr(cb_addr), .cb_data(cb_data),
    .dw_we(dw_we), .dw_addr(dw_addr), .dw_data(dw_data),
    .db_we(db_we), .db_addr(db_addr), .db_data(db_data),
    .busy(busy), .done(done), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  // Write log: each strobe is one cycle wide, so a falling-edge sample sees it exactly once.
  always @(negedge clk) begin
    if (cw_we) begin cwAddrQ.push_back({4'd0, cw_addr}); cwDataQ.push_back(cw_data); end
    if (cb_we) begin cbAddrQ.push_back({9'd0, cb_addr}); cbDataQ.push_back(cb_data); end
    if (dw_we) begin dwAddrQ.push_back(dw_addr); dwDataQ.push_back(dw_data); end
    if (db_we) begin dbAddrQ.push_back({8'd0, db_addr}); dbDataQ.push_back(db_data); end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clearLogs();
    cwAddrQ.delete(); cwDataQ.delete();
    cbAddrQ.delete(); cbDataQ.delete();
    dwAddrQ.delete(); dwDataQ.delete();
    dbAddrQ.delete(); dbDataQ.delete();
  endtask

  task automatic sendByte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sendParam(input logic [15:0] p);
    sendByte(p[7:0]);
    sendByte(p[15:8]);
    tbSum = tbSum + p;
  endtask

  task automatic startPulse();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    tbSum = 16'd0;
  endtask

  task automatic sendCwWord(input logic [15:0] base);
    for (int k = 0; k < 9; k++) sendParam(base + 16'(k));
  endtask

  task automatic sendCbAll();
    for (int i = 0; i < 3; i++) sendParam(16'h0200 + 16'(i));
  endtask

  task automatic sendDwRange(input int first, input int last);
    for (int i = first; i <= last; i++) sendParam(16'h0300 + 16'(i));
  endtask

  task automatic sendDbAll();
    for (int i = 0; i < 2; i++) sendParam(16'h0400 + 16'(i));
  endtask

  task automatic sendChecksum(input logic [15:0] adj);
`ifdef PARAM_CHECKSUM_EN
    logic [15:0] v;
    v = tbSum + adj;
    sendByte(v[7:0]);
    sendByte(v[15:8]);
`else
    if (adj != 16'd0) $display("[TB] checksum phase not present in this build");
`endif
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++; if ({cw_we, cb_we, dw_we, db_we} !== 4'b0) begin miscompares++; $display("[TB] FAIL reset_we: got %b expected 0000", {cw_we, cb_we, dw_we, db_we}); end
    vectors++; if ({cw_addr, cb_addr, dw_addr, db_addr} !== 43'd0) begin miscompares++; $display("[TB] FAIL reset_addr: got %h expected 0", {cw_addr, cb_addr, dw_addr, db_addr}); end
    vectors++; if ({cw_data, cb_data, dw_data, db_data} !== 192'd0) begin miscompares++; $display("[TB] FAIL reset_data: got %h expected 0", {cw_data, cb_data, dw_data, db_data}); end
    vectors++; if ({in_ready, busy, done, chk_err} !== 4'b0) begin miscompares++; $display("[TB] FAIL reset_status: got %b expected 0000", {in_ready, busy, done, chk_err}); end
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(posedge clk);
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_in_ready: got %b expected 0", in_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    clearLogs();
    startPulse();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_busy: got %b expected 1", busy); end
    sendCwWord(16'h0001);
    sendCwWord(16'h1001);
    sendCbAll();
    sendDwRange(0, 3);
    sendDbAll();
    sendChecksum(16'd0);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_done: got %b expected 1", done); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_in_ready: got %b expected 0", in_ready); end
    vectors++; if (chk_err !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_chk_err: got %b expected 0", chk_err); end
    @(negedge clk);
    #1;
    vectors++; if (cwAddrQ.size() !== 2) begin miscompares++; $display("[TB] FAIL b2b_cw_count: got %0d expected 2", cwAddrQ.size()); end
    vectors++; if (cwAddrQ[0] !== 16'd0) begin miscompares++; $display("[TB] FAIL b2b_cw_addr0: got %h expected 0", cwAddrQ[0]); end
    vectors++; if (cwDataQ[0][15:0] !== 16'h0001) begin miscompares++; $display("[TB] FAIL b2b_cw_slot0: got %h expected 0001", cwDataQ[0][15:0]); end
    vectors++; if (cwDataQ[0][143:128] !== 16'h0009) begin miscompares++; $display("[TB] FAIL b2b_cw_slot8: got %h expected 0009", cwDataQ[0][143:128]); end
    vectors++; if (cwAddrQ[1] !== 16'd1) begin miscompares++; $display("[TB] FAIL b2b_cw_addr1: got %h expected 1", cwAddrQ[1]); end
    vectors++; if (cwDataQ[1][79:64] !== 16'h1005) begin miscompares++; $display("[TB] FAIL b2b_cw1_slot4: got %h expected 1005", cwDataQ[1][79:64]); end
    vectors++; if ({cbAddrQ.size(), dwAddrQ.size(), dbAddrQ.size()} !== {32'd3, 32'd4, 32'd2}) begin miscompares++; $display("[TB] FAIL b2b_counts: got cb=%0d dw=%0d db=%0d expected 3 4 2", cbAddrQ.size(), dwAddrQ.size(), dbAddrQ.size()); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if ({cbAddrQ[i], cbDataQ[i]} !== {16'(i), 16'h0200 + 16'(i)}) begin miscompares++; $display("[TB] FAIL b2b_cb%0d: got %h/%h expected %h/%h", i, cbAddrQ[i], cbDataQ[i], 16'(i), 16'h0200 + 16'(i)); end
    end
    for (int i = 0; i < 4; i++) begin
      vectors++; if ({dwAddrQ[i], dwDataQ[i]} !== {16'(i), 16'h0300 + 16'(i)}) begin miscompares++; $display("[TB] FAIL b2b_dw%0d: got %h/%h expected %h/%h", i, dwAddrQ[i], dwDataQ[i], 16'(i), 16'h0300 + 16'(i)); end
    end
    for (int i = 0; i < 2; i++) begin
      vectors++; if ({dbAddrQ[i], dbDataQ[i]} !== {16'(i), 16'h0400 + 16'(i)}) begin miscompares++; $display("[TB] FAIL b2b_db%0d: got %h/%h expected %h/%h", i, dbAddrQ[i], dbDataQ[i], 16'(i), 16'h0400 + 16'(i)); end
    end
  endtask

  task automatic test_stall();
    startPulse();
    clearLogs();
    sendCwWord(16'h0001);
    sendCwWord(16'h1001);
    sendByte(8'h00);
    repeat (5) @(posedge clk);
    #1;
    vectors++; if (cbAddrQ.size() !== 0) begin miscompares++; $display("[TB] FAIL stall_no_we: got %0d writes expected 0", cbAddrQ.size()); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_busy: got %b expected 1", busy); end
    sendByte(8'h80);
    tbSum = tbSum + 16'h8000;
    @(negedge clk);
    #1;
    vectors++; if (cbAddrQ.size() !== 1) begin miscompares++; $display("[TB] FAIL stall_cb_count: got %0d expected 1", cbAddrQ.size()); end
    vectors++; if ({cbAddrQ[0], cbDataQ[0]} !== {16'd0, 16'h8000}) begin miscompares++; $display("[TB] FAIL stall_cb_value: got %h/%h expected 0000/8000", cbAddrQ[0], cbDataQ[0]); end
    sendParam(16'h7FFF);
    sendParam(16'hFFFF);
    sendDwRange(0, 3);
    sendDbAll();
    sendChecksum(16'd0);
    vectors++; if ({done, chk_err} !== 2'b10) begin miscompares++; $display("[TB] FAIL stall_end: got done/chk %b expected 10", {done, chk_err}); end
    vectors++; if ({cbAddrQ[2], cbDataQ[2]} !== {16'd2, 16'hFFFF}) begin miscompares++; $display("[TB] FAIL stall_cb2: got %h/%h expected 0002/ffff", cbAddrQ[2], cbDataQ[2]); end
  endtask

  task automatic test_reset_mid_load();
    startPulse();
    clearLogs();
    sendCwWord(16'h0001);
    sendCwWord(16'h1001);
    sendCbAll();
    sendDwRange(0, 2);
    @(negedge clk);
    #1;
    vectors++; if (dwAddrQ.size() !== 3) begin miscompares++; $display("[TB] FAIL rml_dw_before: got %0d expected 3", dwAddrQ.size()); end
    sendByte(8'h03);
    in_valid = 1'b1;
    in_data  = 8'h03;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    vectors++; if ({busy, in_ready, done, dw_we} !== 4'b0) begin miscompares++; $display("[TB] FAIL rml_idle: got %b expected 0000", {busy, in_ready, done, dw_we}); end
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (dwAddrQ.size() !== 3) begin miscompares++; $display("[TB] FAIL rml_dw_after: got %0d expected 3", dwAddrQ.size()); end
    startPulse();
    clearLogs();
    sendCwWord(16'h2001);
    @(negedge clk);
    #1;
    vectors++; if ({cwAddrQ.size(), cwAddrQ[0]} !== {32'd1, 16'd0}) begin miscompares++; $display("[TB] FAIL rml_cw_restart: got count %0d addr %h expected 1/0000", cwAddrQ.size(), cwAddrQ[0]); end
    vectors++; if (cwDataQ[0][15:0] !== 16'h2001) begin miscompares++; $display("[TB] FAIL rml_cw_data: got %h expected 2001", cwDataQ[0][15:0]); end
    sendCwWord(16'h1001);
    sendCbAll();
    sendDwRange(0, 3);
    sendDbAll();
    sendChecksum(16'd0);
    vectors++; if ({done, chk_err} !== 2'b10) begin miscompares++; $display("[TB] FAIL rml_end: got done/chk %b expected 10", {done, chk_err}); end
  endtask

  task automatic test_start_ignored();
    startPulse();
    clearLogs();
    sendCwWord(16'h0001);
    sendCwWord(16'h1001);
    sendCbAll();
    sendDwRange(0, 0);
    start = 1'b1;
    sendDwRange(1, 1);
    start = 1'b0;
    vectors++; if ({busy, done} !== 2'b10) begin miscompares++; $display("[TB] FAIL sig_state: got busy/done %b expected 10", {busy, done}); end
    sendDwRange(2, 3);
    sendDbAll();
    sendChecksum(16'd0);
    @(negedge clk);
    #1;
    vectors++; if ({cwAddrQ.size(), dwAddrQ.size()} !== {32'd2, 32'd4}) begin miscompares++; $display("[TB] FAIL sig_counts: got cw=%0d dw=%0d expected 2 4", cwAddrQ.size(), dwAddrQ.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (dwAddrQ[i] !== 16'(i)) begin miscompares++; $display("[TB] FAIL sig_dw_addr%0d: got %h expected %h", i, dwAddrQ[i], 16'(i)); end
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL sig_done: got %b expected 1", done); end
  endtask

  task automatic test_restart_from_done();
    startPulse();
    vectors++; if ({done, busy, in_ready} !== 3'b011) begin miscompares++; $display("[TB] FAIL rfd_state: got done/busy/ready %b expected 011", {done, busy, in_ready}); end
    clearLogs();
    sendCwWord(16'h0001);
    sendCwWord(16'h1001);
    sendCbAll();
    sendDwRange(0, 3);
    sendDbAll();
    sendChecksum(16'd0);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL rfd_done: got %b expected 1", done); end
  endtask

  task automatic test_checksum();
    logic expErr;
`ifdef PARAM_CHECKSUM_EN
    expErr = 1'b1;
`else
    expErr = 1'b0;
`endif
    startPulse();
    sendCwWord(16'h0001);
    sendCwWord(16'h1001);
    sendCbAll();
    sendDwRange(0, 3);
    sendDbAll();
    sendChecksum(16'd1);
    vectors++; if ({done, chk_err} !== {1'b1, expErr}) begin miscompares++; $display("[TB] FAIL chk_bad: got done/chk %b expected %b", {done, chk_err}, {1'b1, expErr}); end
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (chk_err !== expErr) begin miscompares++; $display("[TB] FAIL chk_hold: got %b expected %b", chk_err, expErr); end
    startPulse();
    vectors++; if (chk_err !== 1'b0) begin miscompares++; $display("[TB] FAIL chk_clear: got %b expected 0", chk_err); end
    sendCwWord(16'hFFF8);
    sendCwWord(16'h7FF0);
    sendCbAll();
    sendDwRange(0, 3);
    sendDbAll();
    sendChecksum(16'd0);
    vectors++; if ({done, chk_err} !== 2'b10) begin miscompares++; $display("[TB] FAIL chk_good: got done/chk %b expected 10", {done, chk_err}); end
  endtask

  initial begin
    tbSum = 16'd0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_reset_mid_load();
    test_start_ignored();
    test_restart_from_done();
    test_checksum();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
